lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store stage directly downstream of the execute unit: takes its 32-bit result (address or ALU value)
//  plus rs2 data, performs one data-memory access over a req/ack bus, aligns/extends load data, and hands
//  a single writeback record to WBU. Non-memory ops pass through. One op in flight; valid/ready both sides.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting for mem_ack before aborting with out_err (8-bit counter)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   reset, synchronous, active-high
//  in_valid     in   1   EXU record valid
//  in_ready     out  1   LSU can accept record
//  in_exu_data  in   32  EXU result: effective address for ld/st, else writeback value
//  in_st_data   in   32  rs2 value for stores
//  in_ld        in   1   op is a load
//  in_st        in   1   op is a store (in_ld&in_st never both 1)
//  in_funct3    in   3   000 B,001 H,010 W,100 BU,101 HU
//  in_rd        in   5   destination register
//  in_rd_wen    in   1   writes rd (forced 0 for stores)
//  mem_req      out  1   bus request, held until mem_ack
//  mem_we       out  1   1 write / 0 read
//  mem_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated store data
//  mem_wmask    out  4   byte enables
//  mem_ack      in   1   one-cycle completion; mem_rdata valid same cycle
//  mem_rdata    in   32  read word
//  out_valid    out  1   writeback record valid
//  out_ready    in   1   WBU accepts
//  out_data     out  32  load result or pass-through value
//  out_rd       out  5   destination
//  out_rd_wen   out  1   rd write enable (0 on error)
//  out_err      out  1   access fault (timeout, or misalign when enabled)
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; mem_req=mem_we=0; mem_addr/wdata=0; mem_wmask=0; out_valid=0;
//    out_data=0; out_rd=0; out_rd_wen=0; out_err=0; timeout counter=0. Mid-op reset drops the op, no output.
//  - States: IDLE -> (ld|st) BUS | (other) RESP; BUS -> RESP on mem_ack or timeout; RESP -> IDLE on out_ready.
//  - in_ready=1 only in IDLE; accept on in_valid&in_ready; inputs registered at accept.
//  - Pass-through: out_valid one cycle after accept, out_data=in_exu_data, no bus activity.
//  - BUS: mem_req asserted the cycle after accept, held with stable addr/we/wdata/wmask until mem_ack.
//    Counter increments each BUS cycle without ack; reaching TIMEOUT_CYCLES -> deassert req, out_err=1,
//    out_rd_wen=0, out_data=0. Ack on the same cycle the counter hits limit counts as success.
//  - Store: B mask 4'b0001<<a[1:0], wdata {4{d[7:0]}}; H mask 4'b0011<<{a[1],1'b0}, wdata {2{d[15:0]}};
//    W mask 4'b1111, wdata d. Stores complete with out_valid, out_rd_wen=0.
//  - Load: byte/half picked by a[1:0]/a[1]; B/H sign-extend, BU/HU zero-extend, W raw. Undefined funct3
//    treated as W.
//  - Load latency ack->out_valid: 1 cycle (rdata registered). out_* held stable while out_valid&!out_ready.
//  - Fastest: accept, req (ack same cycle), out_valid next, return IDLE on out_ready: 3 cycles/op.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no bus request, go to RESP with
//   out_err=1, out_rd_wen=0, out_data=in_exu_data (faulting address).
//  Not defined: low address bits beyond access size ignored (H uses a[1], W uses word); no misalign fault.
// STRUCTURE
//  - Shared package npc_defs: funct3 size encodings, LSU state encodings, 2'b00 word-offset constant.
//  - Sub-module lsu_align (combinational): store lane shift/mask and load extract/extend; FSM, counter and
//    handshakes in lsu.
// TESTING
//  1 SW addr 0x80000104 data 0xDEADBEEF, ack after 2 cycles -> mem_addr 0x80000104, wmask 1111, out_rd_wen 0
//  2 LB addr 0x80000003, rdata 0x80112233 -> out_data 0xFFFFFF80; LBU same -> 0x00000080
//  3 SH addr 0x80000002 data 0x1234ABCD -> wmask 1100, wdata 0xABCDABCD; LHU rdata 0xBEEF0000 -> 0x0000BEEF
//  4 ALU op exu_data 0x5, rd 7, out_ready low 3 cycles -> out_valid held, data/rd stable, in_ready 0
//  5 LW never acked, TIMEOUT_CYCLES=4 -> req dropped after 4 cycles, out_err 1, out_rd_wen 0
//  6 LW addr 0x80000002: with LSU_MISALIGN_CHECK_EN -> no mem_req, out_err 1; without -> mem_addr 0x80000000

Source files
------------

// File: rtl/npc_defs.sv
// Shared definitions for the load/store stage: funct3 size encodings,
// LSU FSM state encodings and the word-offset constant used to form bus addresses.
package npc_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bus is word addressed; low two address bits are replaced with this.
  localparam logic [1:0] WORD_OFF = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Access width implied by funct3; anything unrecognised is a full word.
  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: acc_size = SZ_B;
      F3_H, F3_HU: acc_size = SZ_H;
      F3_W:        acc_size = SZ_W;
      default:     acc_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte-lane replication and
// byte enables, load byte/half extraction with sign/zero extension, and
// misalignment detection (only active when LSU_MISALIGN_CHECK_EN is defined).
module lsu_align
  import npc_defs::*;
(
  input  logic [2:0]  acc_funct3_i,
  input  logic [1:0]  acc_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wmask_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  acc_size_e   st_sz;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign st_sz = acc_size(acc_funct3_i);

  // Store: replicate the datum across all lanes, enable only the addressed bytes.
  always_comb begin
    st_wdata_o = st_data_i;
    st_wmask_o = 4'b1111;
    case (st_sz)
      SZ_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wmask_o = 4'b0001 << acc_off_i;
      end
      SZ_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wmask_o = 4'b0011 << {acc_off_i[1], 1'b0};
      end
      default: begin
        st_wdata_o = st_data_i;
        st_wmask_o = 4'b1111;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_o = ((st_sz == SZ_H) && acc_off_i[0]) ||
                      ((st_sz == SZ_W) && (acc_off_i != WORD_OFF));
`else
  // Low address bits beyond the access size are simply ignored.
  assign misalign_o = 1'b0;
`endif

  // Load: pick the addressed lane out of the returned word.
  always_comb begin
    ld_b = ld_rdata_i[7:0];
    case (ld_off_i)
      2'd0: ld_b = ld_rdata_i[7:0];
      2'd1: ld_b = ld_rdata_i[15:8];
      2'd2: ld_b = ld_rdata_i[23:16];
      2'd3: ld_b = ld_rdata_i[31:24];
      default: ld_b = ld_rdata_i[7:0];
    endcase
    ld_h = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  // Load: extend the extracted lane according to funct3.
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_b[7]}}, ld_b};
      F3_BU:   ld_data_o = {24'd0, ld_b};
      F3_H:    ld_data_o = {{16{ld_h[15]}}, ld_h};
      F3_HU:   ld_data_o = {16'd0, ld_h};
      F3_W:    ld_data_o = ld_rdata_i;
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: accepts one EXU record at a time, performs at most one
// data-memory access over a req/ack bus with a timeout, and presents a single
// writeback record to WBU. Non-memory ops pass straight through.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault misaligned H/W accesses.
module lsu
  import npc_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_exu_data,
  input  logic [31:0] in_st_data,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_err
);

  // Counter value on the last permitted un-acked BUS cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_wen_q, rd_wen_d;
  logic        err_q, err_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        misalign;
  logic [31:0] ld_data;

  // Store lanes are computed from the live inputs at accept; load lanes from
  // the registered offset/funct3 against the returning bus word.
  lsu_align u_align (
    .acc_funct3_i (in_funct3),
    .acc_off_i    (in_exu_data[1:0]),
    .st_data_i    (in_st_data),
    .st_wdata_o   (st_wdata),
    .st_wmask_o   (st_wmask),
    .misalign_o   (misalign),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (mem_rdata),
    .ld_data_o    (ld_data)
  );

  assign in_ready   = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_BUS);
  assign out_valid  = (state_q == S_RESP);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign out_data   = data_q;
  assign out_rd     = rd_q;
  assign out_rd_wen = rd_wen_q;
  assign out_err    = err_q;

  // Next-state logic; every register holds unless its state acts on it, which
  // keeps the bus and writeback fields stable while waiting on the far side.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    f3_d     = f3_q;
    off_d    = off_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    data_d   = data_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ld_d  = in_ld;
          f3_d  = in_funct3;
          off_d = in_exu_data[1:0];
          rd_d  = in_rd;
          err_d = 1'b0;
          cnt_d = 8'd0;
          if (in_ld || in_st) begin
            if (misalign) begin
              // Fault reports the offending address instead of touching the bus.
              state_d  = S_RESP;
              rd_wen_d = 1'b0;
              err_d    = 1'b1;
              data_d   = in_exu_data;
            end else begin
              state_d  = S_BUS;
              addr_d   = {in_exu_data[31:2], WORD_OFF};
              we_d     = in_st;
              wdata_d  = in_st ? st_wdata : 32'd0;
              wmask_d  = in_st ? st_wmask : 4'd0;
              rd_wen_d = in_ld & in_rd_wen;
              data_d   = 32'd0;
            end
          end else begin
            state_d  = S_RESP;
            data_d   = in_exu_data;
            rd_wen_d = in_rd_wen;
          end
        end
      end
      S_BUS: begin
        // Ack wins over timeout when both land on the same cycle.
        if (mem_ack) begin
          state_d = S_RESP;
          data_d  = ld_q ? ld_data : 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            state_d  = S_RESP;
            err_d    = 1'b1;
            rd_wen_d = 1'b0;
            data_d   = 32'd0;
          end
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset mid-op drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ld_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'd0;
      data_q   <= 32'd0;
      rd_q     <= 5'd0;
      rd_wen_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT_CYCLES=4. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_exu_data, in_st_data;
  logic        in_ld, in_st;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exu_data(in_exu_data), .in_st_data(in_st_data),
    .in_ld(in_ld), .in_st(in_st), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_err(out_err)
  );

  // Present one record for a single rising edge; returns on the following falling edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic wen);
    @(negedge clk);
    in_valid = 1'b1; in_ld = ld; in_st = st; in_funct3 = f3;
    in_exu_data = a; in_st_data = sd; in_rd = rd; in_rd_wen = wen;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Let WBU take the record, leaving the bench on a falling edge in IDLE.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({in_ready, mem_req, mem_we, out_valid, out_rd_wen, out_err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 100000",
               {in_ready, mem_req, mem_we, out_valid, out_rd_wen, out_err});
    end
    tests++;
    if ({mem_addr, mem_wdata, mem_wmask, out_data, out_rd} !== 105'd0) begin
      fails++;
      $display("FAIL reset_data addr=%h wdata=%h mask=%b data=%h rd=%0d want all zero",
               mem_addr, mem_wdata, mem_wmask, out_data, out_rd);
    end
  endtask

  task automatic test_store_word();
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 5'd3, 1'b1);
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 32'h8000_0104, 32'hDEAD_BEEF, 4'b1111}) begin
      fails++;
      $display("FAIL sw_bus req=%b we=%b addr=%h wdata=%h mask=%b want 1 1 80000104 deadbeef 1111",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL sw_busy in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({mem_req, mem_addr, mem_wmask, out_valid} !== {1'b1, 32'h8000_0104, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL sw_hold req=%b addr=%h mask=%b ov=%b want 1 80000104 1111 0",
               mem_req, mem_addr, mem_wmask, out_valid);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({out_valid, out_rd_wen, out_err, mem_req} !== 4'b1000) begin
      fails++;
      $display("FAIL sw_resp ov=%b wen=%b err=%b req=%b want 1 0 0 0",
               out_valid, out_rd_wen, out_err, mem_req);
    end
    drain();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL sw_idle in_ready=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // Single-cycle ack loads; each vector: funct3, address, rdata, expected result.
  task automatic test_loads();
    logic [2:0]  f3 [5];
    logic [31:0] a  [5];
    logic [31:0] rv [5];
    logic [31:0] ex [5];
    f3[0] = 3'b000; a[0] = 32'h8000_0003; rv[0] = 32'h8011_2233; ex[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; a[1] = 32'h8000_0003; rv[1] = 32'h8011_2233; ex[1] = 32'h0000_0080;
    f3[2] = 3'b101; a[2] = 32'h8000_0002; rv[2] = 32'hBEEF_0000; ex[2] = 32'h0000_BEEF;
    f3[3] = 3'b001; a[3] = 32'h8000_0002; rv[3] = 32'hBEEF_0000; ex[3] = 32'hFFFF_BEEF;
    f3[4] = 3'b000; a[4] = 32'h8000_0001; rv[4] = 32'h0000_7F00; ex[4] = 32'h0000_007F;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, f3[i], a[i], 32'd0, 5'(10 + i), 1'b1);
      tests++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, a[i][31:2], 2'b00}) begin
        fails++;
        $display("FAIL ld%0d_bus req=%b we=%b addr=%h want 1 0 %h",
                 i, mem_req, mem_we, mem_addr, {a[i][31:2], 2'b00});
      end
      mem_ack = 1'b1; mem_rdata = rv[i];
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
      tests++;
      if ({out_valid, out_data, out_rd, out_rd_wen, out_err} !== {1'b1, ex[i], 5'(10 + i), 2'b10}) begin
        fails++;
        $display("FAIL ld%0d_data ov=%b data=%h rd=%0d wen=%b err=%b want 1 %h %0d 1 0",
                 i, out_valid, out_data, out_rd, out_rd_wen, out_err, ex[i], 10 + i);
      end
      drain();
    end
  endtask

  task automatic test_store_sub();
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 5'd4, 1'b1);
    tests++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_0000, 32'hABCD_ABCD, 4'b1100}) begin
      fails++;
      $display("FAIL sh addr=%h wdata=%h mask=%b want 80000000 abcdabcd 1100",
               mem_addr, mem_wdata, mem_wmask);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    drain();
    issue(1'b0, 1'b1, 3'b000, 32'h8000_0011, 32'h0000_005A, 5'd4, 1'b1);
    tests++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_0010, 32'h5A5A_5A5A, 4'b0010}) begin
      fails++;
      $display("FAIL sb addr=%h wdata=%h mask=%b want 80000010 5a5a5a5a 0010",
               mem_addr, mem_wdata, mem_wmask);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({out_valid, out_rd_wen} !== 2'b10) begin
      fails++;
      $display("FAIL sb_resp ov=%b wen=%b want 1 0", out_valid, out_rd_wen);
    end
    drain();
  endtask

  task automatic test_passthrough_stall();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0005, 32'd0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, out_data, out_rd, out_rd_wen, out_err, in_ready, mem_req} !== {1'b1, 32'h5, 5'd7, 4'b1000}) begin
        fails++;
        $display("FAIL alu_hold%0d ov=%b data=%h rd=%0d wen=%b err=%b in_ready=%b req=%b want 1 5 7 1 0 0 0",
                 i, out_valid, out_data, out_rd, out_rd_wen, out_err, in_ready, mem_req);
      end
      @(negedge clk);
    end
    drain();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL alu_done ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_timeout();
    int  reqs = 0;
    bit  done = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd8, 1'b1);
    for (int i = 0; i < 12 && !done; i++) begin
      if (mem_req) reqs++;
      if (out_valid) done = 1;
      else @(negedge clk);
    end
    tests++;
    if (!done || reqs != 4) begin
      fails++;
      $display("FAIL timeout_len done=%0d req_cycles=%0d want 1 4", done, reqs);
    end
    tests++;
    if ({mem_req, out_err, out_rd_wen, out_data} !== {3'b010, 32'd0}) begin
      fails++;
      $display("FAIL timeout_resp req=%b err=%b wen=%b data=%h want 0 1 0 0",
               mem_req, out_err, out_rd_wen, out_data);
    end
    drain();
    // Ack on the final allowed cycle still succeeds.
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0, 5'd9, 1'b1);
    repeat (3) @(negedge clk);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL lastack_req req=%b want 1", mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({out_valid, out_err, out_rd_wen, out_data} !== {3'b101, 32'hCAFE_F00D}) begin
      fails++;
      $display("FAIL lastack_resp ov=%b err=%b wen=%b data=%h want 1 0 1 cafef00d",
               out_valid, out_err, out_rd_wen, out_data);
    end
    drain();
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0, 5'd6, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
    tests++;
    if ({mem_req, out_valid, out_err, out_rd_wen, out_data} !== {4'b0110, 32'h8000_0002}) begin
      fails++;
      $display("FAIL misalign_fault req=%b ov=%b err=%b wen=%b data=%h want 0 1 1 0 80000002",
               mem_req, out_valid, out_err, out_rd_wen, out_data);
    end
`else
    tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0000}) begin
      fails++;
      $display("FAIL misalign_bus req=%b addr=%h want 1 80000000", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({out_valid, out_err, out_data} !== {2'b10, 32'h1122_3344}) begin
      fails++;
      $display("FAIL misalign_data ov=%b err=%b data=%h want 1 0 11223344",
               out_valid, out_err, out_data);
    end
`endif
    drain();
  endtask

  task automatic test_midop_reset();
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0, 5'd2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({mem_req, out_valid, in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL midop_reset req=%b ov=%b in_ready=%b want 0 0 1", mem_req, out_valid, in_ready);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midop_nout ov=%b want 0", out_valid);
    end
  endtask

  // Continuous supply with immediate ack and ready: one result every 3 cycles.
  task automatic test_back_to_back();
    int nvalid = 0;
    int bad = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_funct3 = 3'b100;
    in_exu_data = 32'h8000_0001; in_rd = 5'd5; in_rd_wen = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_A500; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        if (out_data !== 32'h0000_00A5) bad++;
      end
    end
    in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
    tests++;
    if (nvalid != 3 || bad != 0) begin
      fails++;
      $display("FAIL b2b results=%0d wrong_data=%0d want 3 0", nvalid, bad);
    end
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, mem_req} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_idle in_ready=%b ov=%b req=%b want 1 0 0", in_ready, out_valid, mem_req);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_funct3 = 3'd0;
    in_exu_data = 32'd0; in_st_data = 32'd0; in_rd = 5'd0; in_rd_wen = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    test_reset();
    test_store_word();
    test_loads();
    test_store_sub();
    test_passthrough_stall();
    test_timeout();
    test_misalign();
    test_midop_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
